// File: rtl/pc_pkg.sv
// Shared encodings for the fetch next-PC sequencer: PC mux selects, redirect ranks, FSM states.
package pc_pkg;

  localparam logic [2:0] PC_SEL_PC4  = 3'd0;
  localparam logic [2:0] PC_SEL_JALR = 3'd1;
  localparam logic [2:0] PC_SEL_BR   = 3'd2;
  localparam logic [2:0] PC_SEL_JMP  = 3'd3;
  localparam logic [2:0] PC_SEL_EXCP = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } pc_state_e;

  // Select encodings are not in priority order; map them to ranks 4..0.
  function automatic logic [2:0] pc_sel_rank(input logic [2:0] sel);
    case (sel)
      PC_SEL_EXCP: pc_sel_rank = 3'd4;
      PC_SEL_JALR: pc_sel_rank = 3'd3;
      PC_SEL_BR:   pc_sel_rank = 3'd2;
      PC_SEL_JMP:  pc_sel_rank = 3'd1;
      default:     pc_sel_rank = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Fetch-side bus between the next-PC sequencer and the surrounding pipeline / PC mux.
interface pc_seq_ctrl_if;
  logic        io_stall;
  logic        io_imem_ready;
  logic        io_excp_valid;
  logic        io_jalr_valid;
  logic        io_br_taken;
  logic        io_jmp_valid;
  logic [31:0] io_pc_next;
  logic [2:0]  io_pc_sel;
  logic [31:0] io_pc;
  logic        io_imem_req_valid;
  logic        io_kill;
  logic        io_excp_ack;

  modport slave (
    input  io_stall, io_imem_ready, io_excp_valid, io_jalr_valid, io_br_taken,
           io_jmp_valid, io_pc_next,
    output io_pc_sel, io_pc, io_imem_req_valid, io_kill, io_excp_ack
  );

  modport master (
    output io_stall, io_imem_ready, io_excp_valid, io_jalr_valid, io_br_taken,
           io_jmp_valid, io_pc_next,
    input  io_pc_sel, io_pc, io_imem_req_valid, io_kill, io_excp_ack
  );
endinterface

// File: rtl/pc_redirect_prio.sv
// Combinational redirect priority encoder: EXCP > JALR > BR > JMP > PC4.
module pc_redirect_prio
  import pc_pkg::*;
(
  input  logic       excp_valid,
  input  logic       jalr_valid,
  input  logic       br_taken,
  input  logic       jmp_valid,
  output logic       any_redirect,
  output logic [2:0] sel
);

  always_comb begin
    sel = PC_SEL_PC4;
    if      (excp_valid) sel = PC_SEL_EXCP;
    else if (jalr_valid) sel = PC_SEL_JALR;
    else if (br_taken)   sel = PC_SEL_BR;
    else if (jmp_valid)  sel = PC_SEL_JMP;
  end

  assign any_redirect = excp_valid | jalr_valid | br_taken | jmp_valid;

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: owns the fetch PC, drives the external PC mux select, buffers
// redirects while imem is busy and blanks fetch for EXCP_DRAIN cycles after a trap.
module pc_seq_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC  = 32'h0000_2000,
  parameter int          EXCP_DRAIN = 2
) (
  input  logic         clk,
  input  logic         reset,
  pc_seq_ctrl_if.slave pc_bus
);

  pc_state_e   state;
  logic [31:0] pc_q;
  logic [2:0]  buf_sel;
  logic [31:0] buf_tgt;
  logic [3:0]  drain_cnt;
  logic        kill_q;
  logic        ack_q;

  logic        redir_any;
  logic [2:0]  redir_sel;
  logic [2:0]  sel_c;
  logic        overwrite;
  logic [2:0]  hold_sel;

  pc_redirect_prio u_prio (
    .excp_valid   (pc_bus.io_excp_valid),
    .jalr_valid   (pc_bus.io_jalr_valid),
    .br_taken     (pc_bus.io_br_taken),
    .jmp_valid    (pc_bus.io_jmp_valid),
    .any_redirect (redir_any),
    .sel          (redir_sel)
  );

  // Equal rank overwrites so the youngest target of a repeated redirect type wins.
  assign overwrite = redir_any && (pc_sel_rank(redir_sel) >= pc_sel_rank(buf_sel));

  always_comb begin
    sel_c    = PC_SEL_PC4;
    hold_sel = overwrite ? redir_sel : buf_sel;
    case (state)
      ST_RUN, ST_HOLD: sel_c = redir_any ? redir_sel : PC_SEL_PC4;
      ST_DRAIN:        sel_c = pc_bus.io_excp_valid ? PC_SEL_EXCP : PC_SEL_PC4;
      default:         sel_c = PC_SEL_PC4;
    endcase
    if (reset) sel_c = PC_SEL_PC4;
  end

  assign pc_bus.io_pc_sel         = sel_c;
  assign pc_bus.io_pc             = pc_q;
  assign pc_bus.io_imem_req_valid = !reset && (state != ST_DRAIN);
  assign pc_bus.io_kill           = kill_q;
  assign pc_bus.io_excp_ack       = ack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pc_q      <= RESET_VEC;
      buf_sel   <= PC_SEL_PC4;
      buf_tgt   <= '0;
      drain_cnt <= '0;
      kill_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      kill_q <= 1'b0;
      ack_q  <= 1'b0;
      case (state)
        ST_RUN: begin
          if (redir_any) begin
            if (pc_bus.io_imem_ready) begin
              pc_q   <= pc_bus.io_pc_next;
              kill_q <= 1'b1;
              if (redir_sel == PC_SEL_EXCP) begin
                ack_q     <= 1'b1;
                drain_cnt <= 4'(EXCP_DRAIN);
                state     <= ST_DRAIN;
              end
            end else begin
              buf_sel <= redir_sel;
              buf_tgt <= pc_bus.io_pc_next;
              state   <= ST_HOLD;
            end
          end else if (pc_bus.io_imem_ready && !pc_bus.io_stall) begin
            pc_q <= pc_bus.io_pc_next;
          end
        end
        ST_HOLD: begin
          if (pc_bus.io_imem_ready) begin
            pc_q   <= overwrite ? pc_bus.io_pc_next : buf_tgt;
            kill_q <= 1'b1;
            if (hold_sel == PC_SEL_EXCP) begin
              ack_q     <= 1'b1;
              drain_cnt <= 4'(EXCP_DRAIN);
              state     <= ST_DRAIN;
            end else begin
              state <= ST_RUN;
            end
          end else if (overwrite) begin
            buf_sel <= redir_sel;
            buf_tgt <= pc_bus.io_pc_next;
          end
        end
        ST_DRAIN: begin
          // A nested trap restarts the blanking window without waiting on imem.
          if (pc_bus.io_excp_valid) begin
            pc_q      <= pc_bus.io_pc_next;
            drain_cnt <= 4'(EXCP_DRAIN);
            ack_q     <= 1'b1;
            kill_q    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
            if (drain_cnt <= 4'd1) state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl; the external PC mux is modelled here.
module tb_pc_seq_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] jalr_tgt, br_tgt, jmp_tgt, excp_tgt;

  pc_seq_ctrl_if bus ();

  pc_seq_ctrl #(.RESET_VEC(32'h0000_2000), .EXCP_DRAIN(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .pc_bus (bus.slave)
  );

  always #5 clk = ~clk;

  // External PC mux
  always_comb begin
    case (bus.io_pc_sel)
      3'd1:    bus.io_pc_next = jalr_tgt;
      3'd2:    bus.io_pc_next = br_tgt;
      3'd3:    bus.io_pc_next = jmp_tgt;
      3'd4:    bus.io_pc_next = excp_tgt;
      default: bus.io_pc_next = bus.io_pc + 32'd4;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.io_stall = 0; bus.io_imem_ready = 1; bus.io_excp_valid = 0;
    bus.io_jalr_valid = 0; bus.io_br_taken = 0; bus.io_jmp_valid = 0;
    jalr_tgt = 0; br_tgt = 0; jmp_tgt = 0; excp_tgt = 0;
    tick(); tick();
    chk("rst_req_valid", 32'(bus.io_imem_req_valid), 0);
    chk("rst_pc", bus.io_pc, 32'h2000);
    chk("rst_sel", 32'(bus.io_pc_sel), 0);
    chk("rst_kill", 32'(bus.io_kill), 0);
    chk("rst_ack", 32'(bus.io_excp_ack), 0);

    // 1: sequential fetch
    reset = 1'b0; settle();
    chk("t1_req_valid", 32'(bus.io_imem_req_valid), 1);
    chk("t1_pc0", bus.io_pc, 32'h2000);
    chk("t1_sel", 32'(bus.io_pc_sel), 0);
    tick();
    chk("t1_pc1", bus.io_pc, 32'h2004);
    chk("t1_kill1", 32'(bus.io_kill), 0);
    tick();
    chk("t1_pc2", bus.io_pc, 32'h2008);
    chk("t1_kill2", 32'(bus.io_kill), 0);

    // 2: taken branch, then the same under stall
    bus.io_br_taken = 1; br_tgt = 32'h3000; settle();
    chk("t2_sel", 32'(bus.io_pc_sel), 2);
    tick(); bus.io_br_taken = 0;
    chk("t2_pc", bus.io_pc, 32'h3000);
    chk("t2_kill", 32'(bus.io_kill), 1);
    tick();
    chk("t2_kill_once", 32'(bus.io_kill), 0);
    chk("t2_pc_adv", bus.io_pc, 32'h3004);
    bus.io_stall = 1; bus.io_br_taken = 1; br_tgt = 32'h3100;
    tick(); bus.io_br_taken = 0;
    chk("t2s_pc", bus.io_pc, 32'h3100);
    chk("t2s_kill", 32'(bus.io_kill), 1);
    tick();
    chk("t2s_pc_held", bus.io_pc, 32'h3100);
    chk("t2s_kill_once", 32'(bus.io_kill), 0);
    bus.io_stall = 0;

    // 3: JALR beats BR
    bus.io_jalr_valid = 1; bus.io_br_taken = 1; jalr_tgt = 32'h5000; br_tgt = 32'h3000; settle();
    chk("t3_sel", 32'(bus.io_pc_sel), 1);
    tick(); bus.io_jalr_valid = 0; bus.io_br_taken = 0;
    chk("t3_pc", bus.io_pc, 32'h5000);
    tick();
    chk("t3_pc_adv", bus.io_pc, 32'h5004);

    // 4: BR buffered, lower-rank JMP ignored, released on ready
    bus.io_imem_ready = 0; bus.io_br_taken = 1; br_tgt = 32'h3000; settle();
    chk("t4_sel_br", 32'(bus.io_pc_sel), 2);
    tick(); bus.io_br_taken = 0;
    chk("t4_pc_hold1", bus.io_pc, 32'h5004);
    chk("t4_kill_hold", 32'(bus.io_kill), 0);
    bus.io_jmp_valid = 1; jmp_tgt = 32'h4000; settle();
    chk("t4_sel_jmp", 32'(bus.io_pc_sel), 3);
    tick(); bus.io_jmp_valid = 0; settle();
    chk("t4_sel_idle", 32'(bus.io_pc_sel), 0);
    chk("t4_pc_hold2", bus.io_pc, 32'h5004);
    tick(); bus.io_imem_ready = 1;
    tick();
    chk("t4_pc", bus.io_pc, 32'h3000);
    chk("t4_kill", 32'(bus.io_kill), 1);
    tick();
    chk("t4_kill_once", 32'(bus.io_kill), 0);
    chk("t4_pc_adv", bus.io_pc, 32'h3004);

    // 4b: higher-rank redirect overwrites in the cycle imem becomes ready
    bus.io_imem_ready = 0; bus.io_jmp_valid = 1; jmp_tgt = 32'h4000;
    tick(); bus.io_jmp_valid = 0;
    bus.io_jalr_valid = 1; jalr_tgt = 32'h6000; bus.io_imem_ready = 1;
    tick(); bus.io_jalr_valid = 0;
    chk("t4b_pc", bus.io_pc, 32'h6000);
    chk("t4b_kill", 32'(bus.io_kill), 1);

    // 3b + 5: EXCP swallows JMP, two blank cycles, BR in drain ignored
    bus.io_excp_valid = 1; bus.io_jmp_valid = 1; excp_tgt = 32'h100; jmp_tgt = 32'h4000; settle();
    chk("t5_sel", 32'(bus.io_pc_sel), 4);
    tick(); bus.io_excp_valid = 0; bus.io_jmp_valid = 0;
    chk("t5_pc", bus.io_pc, 32'h100);
    chk("t5_ack", 32'(bus.io_excp_ack), 1);
    chk("t5_kill", 32'(bus.io_kill), 1);
    chk("t5_blank1", 32'(bus.io_imem_req_valid), 0);
    bus.io_br_taken = 1; br_tgt = 32'h7000; settle();
    chk("t5_sel_br_drain", 32'(bus.io_pc_sel), 0);
    tick(); bus.io_br_taken = 0;
    chk("t5_ack_once", 32'(bus.io_excp_ack), 0);
    chk("t5_blank2", 32'(bus.io_imem_req_valid), 0);
    chk("t5_pc_drain", bus.io_pc, 32'h100);
    tick();
    chk("t5_resume", 32'(bus.io_imem_req_valid), 1);
    chk("t5_resume_pc", bus.io_pc, 32'h100);
    tick();
    chk("t5_pc_adv", bus.io_pc, 32'h104);

    // 5b: nested EXCP during drain with imem not ready reloads the window
    bus.io_excp_valid = 1; excp_tgt = 32'h100;
    tick(); bus.io_excp_valid = 0;
    bus.io_excp_valid = 1; excp_tgt = 32'h200; bus.io_imem_ready = 0; settle();
    chk("t5b_sel", 32'(bus.io_pc_sel), 4);
    tick(); bus.io_excp_valid = 0; bus.io_imem_ready = 1;
    chk("t5b_pc", bus.io_pc, 32'h200);
    chk("t5b_ack", 32'(bus.io_excp_ack), 1);
    tick();
    chk("t5b_blank2", 32'(bus.io_imem_req_valid), 0);
    tick();
    chk("t5b_resume", 32'(bus.io_imem_req_valid), 1);

    // 6: reset while holding a buffered redirect
    bus.io_imem_ready = 0; bus.io_br_taken = 1; br_tgt = 32'h3000;
    tick(); bus.io_br_taken = 0; reset = 1;
    tick();
    chk("t6_pc_rst", bus.io_pc, 32'h2000);
    chk("t6_req_rst", 32'(bus.io_imem_req_valid), 0);
    reset = 0; bus.io_imem_ready = 1; settle();
    chk("t6_req", 32'(bus.io_imem_req_valid), 1);
    chk("t6_sel", 32'(bus.io_pc_sel), 0);
    tick();
    chk("t6_pc_adv", bus.io_pc, 32'h2004);
    chk("t6_kill", 32'(bus.io_kill), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
